// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command scheduler: FSM states,
// the command payload and the HD44780 power-up command list.
package lcd_pkg;

  typedef enum logic [2:0] {
    POR_WAIT,
    INIT_ISSUE,
    XFER,
    GAP,
    IDLE
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_HOME   = 8'h02;
  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_MODE = 8'h06;

  localparam int unsigned INIT_LEN = 6;

  // Entry 0 is the first command sent after the power-on wait.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    ENTRY_MODE, CMD_CLEAR, DISP_ON, FUNC_SET, FUNC_SET, FUNC_SET
  };

  // Clear and home are the slow HD44780 instructions needing the long gap.
  function automatic logic is_slow_cmd(input lcd_cmd_t c);
    return !c.rs && ((c.data == CMD_CLEAR) || (c.data == CMD_HOME));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: grants the lowest requester strictly
// after the last winner, wrapping; the pointer moves only on update.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    update,
  output logic [NREQ-1:0]         grant_c,
  output logic [$clog2(NREQ)-1:0] grant_idx_c,
  output logic                    any_c
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;
  logic          hi_found;
  logic          lo_found;

  // Search above the pointer first, then wrap to the bottom.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !hi_found && (PW'(i) > ptr)) begin
        hi_idx   = PW'(i);
        hi_found = 1'b1;
      end
      if (req[i] && !lo_found && (PW'(i) <= ptr)) begin
        lo_idx   = PW'(i);
        lo_found = 1'b1;
      end
    end
    any_c       = hi_found | lo_found;
    grant_idx_c = hi_found ? hi_idx : lo_idx;
    grant_c     = '0;
    grant_c[grant_idx_c] = any_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= PW'(NREQ - 1);
    end else if (update && any_c) begin
      ptr <= grant_idx_c;
    end
  end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Owns the single send_FSM channel: power-on wait, fixed init list, then
// round-robin service of requesters with per-command LCD execution gaps.
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned POR_CYCLES = 20000,
  parameter int unsigned CMD_GAP    = 50,
  parameter int unsigned CLR_GAP    = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rs,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              dataReady,
  output logic              RSin,
  output logic              RWin,
  output logic [7:0]        dataIn,
  input  logic              dataDone,
  output logic              init_done,
  output logic              busy
);

  localparam int unsigned MAX_CNT = (POR_CYCLES > CLR_GAP) ? POR_CYCLES : CLR_GAP;
  localparam int unsigned CW      = $clog2(MAX_CNT) + 1;
  localparam int unsigned PW      = $clog2(NREQ);
  localparam int unsigned IW      = $clog2(INIT_LEN);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IW-1:0]   init_idx, init_idx_d;
  logic [PW-1:0]   owner, owner_d;
  logic            owner_vld, owner_vld_d;
  lcd_cmd_t        cmd, cmd_d;
  logic            dr_d;
  logic [NREQ-1:0] ack_d;
  logic            init_done_d;
  logic            busy_d;

  logic            arb_update_c;
  logic [NREQ-1:0] grant_c;
  logic [PW-1:0]   grant_idx_c;
  logic            any_c;
  lcd_cmd_t        sel_cmd_c;
  logic [CW-1:0]   gap_last_c;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .update     (arb_update_c),
    .grant_c    (grant_c),
    .grant_idx_c(grant_idx_c),
    .any_c      (any_c)
  );

  assign RWin   = 1'b0;
  assign RSin   = cmd.rs;
  assign dataIn = cmd.data;

  // Byte and RS of the winning requester.
  always_comb begin
    sel_cmd_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_cmd_c.rs   = req_rs[i];
        sel_cmd_c.data = req_data[8*i +: 8];
      end
    end
  end

  assign gap_last_c = is_slow_cmd(cmd) ? CW'(CLR_GAP - 1) : CW'(CMD_GAP - 1);

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    init_idx_d   = init_idx;
    owner_d      = owner;
    owner_vld_d  = owner_vld;
    cmd_d        = cmd;
    dr_d         = dataReady;
    ack_d        = '0;
    init_done_d  = init_done;
    arb_update_c = 1'b0;

    case (state)
      POR_WAIT: begin
        if (cnt == CW'(POR_CYCLES - 1)) begin
          cnt_d      = '0;
          init_idx_d = '0;
          state_d    = INIT_ISSUE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      INIT_ISSUE: begin
        cmd_d.rs    = 1'b0;
        cmd_d.data  = INIT_ROM[init_idx];
        owner_vld_d = 1'b0;
        dr_d        = 1'b1;
        state_d     = XFER;
      end
      XFER: begin
        if (dataDone) begin
          dr_d    = 1'b0;
          cnt_d   = '0;
          state_d = GAP;
          if (owner_vld) begin
            ack_d[owner] = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt == gap_last_c) begin
          cnt_d = '0;
          if (init_done) begin
            state_d = IDLE;
          end else if (init_idx == IW'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            init_idx_d = init_idx + IW'(1);
            state_d    = INIT_ISSUE;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      IDLE: begin
        if (any_c) begin
          arb_update_c = 1'b1;
          owner_d      = grant_idx_c;
          owner_vld_d  = 1'b1;
          cmd_d        = sel_cmd_c;
          dr_d         = 1'b1;
          state_d      = XFER;
        end
      end
      default: begin
        state_d = POR_WAIT;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= POR_WAIT;
      cnt       <= '0;
      init_idx  <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      cmd       <= '0;
      dataReady <= 1'b0;
      ack       <= '0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      init_idx  <= init_idx_d;
      owner     <= owner_d;
      owner_vld <= owner_vld_d;
      cmd       <= cmd_d;
      dataReady <= dr_d;
      ack       <= ack_d;
      init_done <= init_done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler: init sequence, round-robin service
// with gap timing, held-off requests, spurious strobes and mid-transfer reset.
module tb_lcd_cmd_scheduler;

  localparam int unsigned NREQ = 2;
  localparam int unsigned POR  = 20;
  localparam int unsigned CG   = 3;
  localparam int unsigned LG   = 10;
  localparam int          DONE_LAT = 4;

  typedef struct {
    int         rise;
    int         fall;
    logic       rs;
    logic [7:0] data;
    logic [1:0] ack;
    logic       initd;
  } xfer_t;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } init_t;

  typedef struct {
    logic [1:0] req;
    logic       rs0;
    logic [7:0] d0;
    logic       rs1;
    logic [7:0] d1;
    int         exp_idx;
    logic       exp_rs;
    logic [7:0] exp_data;
    int         gap_before;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic        dataReady;
  logic        RSin;
  logic        RWin;
  logic [7:0]  dataIn;
  logic        dataDone;
  logic        init_done;
  logic        busy;

  logic model_done = 1'b0;
  logic spur = 1'b0;
  int   mcnt = 0;
  int   cyc;
  int   tests = 0;
  int   fails = 0;
  int   rw_bad = 0;
  int   stab_bad = 0;
  int   stray_ack = 0;
  logic prev_dr = 1'b0;
  xfer_t cur;
  xfer_t xq[$];

  init_t it[6];
  vec_t  vt[11];

  lcd_cmd_scheduler #(
    .NREQ      (NREQ),
    .POR_CYCLES(POR),
    .CMD_GAP   (CG),
    .CLR_GAP   (LG)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_rs   (req_rs),
    .req_data (req_data),
    .ack      (ack),
    .dataReady(dataReady),
    .RSin     (RSin),
    .RWin     (RWin),
    .dataIn   (dataIn),
    .dataDone (dataDone),
    .init_done(init_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign dataDone = model_done | spur;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // send_FSM stand-in: strobe sampled DONE_LAT edges after dataReady rises.
  always @(negedge clk) begin
    if (reset || !dataReady || model_done) begin
      model_done = 1'b0;
      mcnt       = 0;
    end else if (mcnt == DONE_LAT - 1) begin
      model_done = 1'b1;
      mcnt       = 0;
    end else begin
      mcnt = mcnt + 1;
    end
  end

  // Transfer recorder.
  always @(negedge clk) begin
    if (reset) begin
      prev_dr = 1'b0;
    end else begin
      if (RWin !== 1'b0) rw_bad++;
      if (dataReady && !prev_dr) begin
        cur.rise  = cyc;
        cur.rs    = RSin;
        cur.data  = dataIn;
        cur.initd = init_done;
      end else if (dataReady && ((RSin !== cur.rs) || (dataIn !== cur.data))) begin
        stab_bad++;
      end
      if (!dataReady && prev_dr) begin
        cur.fall = cyc;
        cur.ack  = ack;
        xq.push_back(cur);
      end else if (ack != 2'b00) begin
        stray_ack++;
      end
      prev_dr = dataReady;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic get_xfer(output xfer_t x, input string tag);
    bit ok;
    ok = 1'b0;
    x  = '{default: '0};
    for (int i = 0; i < 300 && !ok; i++) begin
      if (xq.size() > 0) begin
        x  = xq.pop_front();
        ok = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    check({tag, "_arrive"}, int'(ok), 1);
  endtask

  task automatic run_init(input string tag, output int next_rise);
    xfer_t x;
    int    exp_rise;
    exp_rise = POR + 1;
    for (int i = 0; i < 6; i++) begin
      get_xfer(x, $sformatf("%s%0d", tag, i));
      check($sformatf("%s%0d_data", tag, i), int'(x.data), int'(it[i].data));
      check($sformatf("%s%0d_rs", tag, i), int'(x.rs), 0);
      check($sformatf("%s%0d_ack", tag, i), int'(x.ack), 0);
      check($sformatf("%s%0d_initd", tag, i), int'(x.initd), 0);
      check($sformatf("%s%0d_rise", tag, i), x.rise, exp_rise);
      check($sformatf("%s%0d_fall", tag, i), x.fall, exp_rise + DONE_LAT);
      exp_rise = exp_rise + DONE_LAT + it[i].gap + 1;
    end
    next_rise = exp_rise;
  endtask

  initial begin
    xfer_t x;
    int    exp_rise;
    int    prev_fall;
    bit    seen;

    it[0] = '{8'h38, CG};
    it[1] = '{8'h38, CG};
    it[2] = '{8'h38, CG};
    it[3] = '{8'h0C, CG};
    it[4] = '{8'h01, LG};
    it[5] = '{8'h06, CG};

    //        req    rs0   d0     rs1   d1     idx rs    data   gap
    vt[0]  = '{2'b11, 1'b1, 8'h41, 1'b1, 8'h42, 1, 1'b1, 8'h42, CG};
    vt[1]  = '{2'b11, 1'b1, 8'h41, 1'b1, 8'h42, 0, 1'b1, 8'h41, CG};
    vt[2]  = '{2'b11, 1'b1, 8'h41, 1'b1, 8'h42, 1, 1'b1, 8'h42, CG};
    vt[3]  = '{2'b11, 1'b1, 8'h41, 1'b1, 8'h42, 0, 1'b1, 8'h41, CG};
    vt[4]  = '{2'b10, 1'b1, 8'h41, 1'b0, 8'h01, 1, 1'b0, 8'h01, CG};
    vt[5]  = '{2'b10, 1'b1, 8'h41, 1'b1, 8'h01, 1, 1'b1, 8'h01, LG};
    vt[6]  = '{2'b01, 1'b0, 8'h02, 1'b1, 8'h01, 0, 1'b0, 8'h02, CG};
    vt[7]  = '{2'b11, 1'b1, 8'h43, 1'b1, 8'h44, 1, 1'b1, 8'h44, LG};
    vt[8]  = '{2'b11, 1'b0, 8'h80, 1'b1, 8'h44, 0, 1'b0, 8'h80, CG};
    vt[9]  = '{2'b10, 1'b0, 8'h80, 1'b0, 8'h02, 1, 1'b0, 8'h02, CG};
    vt[10] = '{2'b11, 1'b1, 8'h45, 1'b1, 8'h46, 0, 1'b1, 8'h45, LG};

    reset    = 1'b1;
    req      = 2'b00;
    req_rs   = 2'b00;
    req_data = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dataReady", int'(dataReady), 0);
    check("rst_RSin", int'(RSin), 0);
    check("rst_RWin", int'(RWin), 0);
    check("rst_dataIn", int'(dataIn), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_busy", int'(busy), 1);

    @(negedge clk);
    reset = 1'b0;

    // Request raised during init must be held off, then served.
    repeat (5) @(posedge clk);
    #1;
    req      = 2'b01;
    req_rs   = 2'b01;
    req_data = 16'h0041;

    run_init("init", exp_rise);

    get_xfer(x, "held");
    check("held_data", int'(x.data), 8'h41);
    check("held_rs", int'(x.rs), 1);
    check("held_initd", int'(x.initd), 1);
    check("held_rise", x.rise, exp_rise);
    check("held_ack", int'(x.ack), 1);
    prev_fall = x.fall;

    for (int v = 0; v < 11; v++) begin
      #1;
      req      = vt[v].req;
      req_rs   = {vt[v].rs1, vt[v].rs0};
      req_data = {vt[v].d1, vt[v].d0};
      get_xfer(x, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_data", v), int'(x.data), int'(vt[v].exp_data));
      check($sformatf("vec%0d_rs", v), int'(x.rs), int'(vt[v].exp_rs));
      check($sformatf("vec%0d_ack", v), int'(x.ack), 1 << vt[v].exp_idx);
      check($sformatf("vec%0d_rise", v), x.rise, prev_fall + vt[v].gap_before + 1);
      check($sformatf("vec%0d_fall", v), x.fall, x.rise + DONE_LAT);
      prev_fall = x.fall;
    end

    // Request pulsed and dropped while the scheduler is still in its gap.
    #1;
    req      = 2'b10;
    req_rs   = 2'b10;
    req_data = 16'h5500;
    @(posedge clk);
    #1;
    req = 2'b00;
    repeat (20) @(posedge clk);
    #1;
    check("drop_no_xfer", xq.size(), 0);
    check("drop_idle_busy", int'(busy), 0);

    // Stray completion strobe while idle.
    spur = 1'b1;
    @(posedge clk);
    #1;
    spur = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("spur_busy", int'(busy), 0);
    check("spur_dataReady", int'(dataReady), 0);
    check("spur_no_xfer", xq.size(), 0);
    check("spur_no_ack", stray_ack, 0);

    // Reset in the middle of a requester transfer.
    req      = 2'b01;
    req_rs   = 2'b01;
    req_data = 16'h0047;
    seen     = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = dataReady;
    end
    check("mid_xfer_started", int'(seen), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_dataReady", int'(dataReady), 0);
    check("mid_rst_ack", int'(ack), 0);
    check("mid_rst_busy", int'(busy), 1);
    check("mid_rst_init_done", int'(init_done), 0);
    check("mid_rst_dataIn", int'(dataIn), 0);
    req = 2'b00;
    xq.delete();
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_ack_hold", int'(ack), 0);
    @(negedge clk);
    reset = 1'b0;

    run_init("reinit", exp_rise);
    repeat (CG + 4) @(posedge clk);
    #1;
    check("reinit_done", int'(init_done), 1);
    check("reinit_idle", int'(busy), 0);
    check("reinit_no_xfer", xq.size(), 0);

    check("rwin_always_zero", rw_bad, 0);
    check("xfer_stable", stab_bad, 0);
    check("stray_ack", stray_ack, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
